// File: rtl/game_pkg.sv
// game_pkg: shared types and helpers for the pattern-game player checker.
// Contents: checker FSM state enum, 2-bit symbol type, key-to-symbol encoder.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT_KEY,
        S_WAIT_REL,
        S_PASS,
        S_FAIL
    } chk_state_t;

    typedef logic [1:0] sym_t;

    // Highest set bit wins; callers must qualify the result with a one-hot check.
    function automatic sym_t key_to_sym(input logic [3:0] key);
        return key[3] ? 2'd3 : key[2] ? 2'd2 : key[1] ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/press_detect.sv
// press_detect: turns the level key bus into single-cycle press events.
// Ports: i_clk, i_rst_n (async active-low), i_key (one-hot level buttons);
//        o_press (rising edge of "any key down"), o_valid (exactly one key down),
//        o_sym (encoded symbol of the key).
module press_detect
    import game_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_key,
    output logic       o_press,
    output logic       o_valid,
    output sym_t       o_sym
);

    logic w_key_nz;
    logic r_key_nz;

    assign w_key_nz = |i_key;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_key_nz <= 1'b0;
        else          r_key_nz <= w_key_nz;
    end

    // A key held across steps never re-fires until every key is released.
    assign o_press = w_key_nz & ~r_key_nz;
    assign o_valid = $onehot(i_key);
    assign o_sym   = key_to_sym(i_key);

endmodule

// File: rtl/seq_checker.sv
// seq_checker: captures SEQ_LEN pattern symbols on start, then checks player key presses.
// Ports: i_clk, i_rst_n (async active-low), i_start (pulse), i_stage1..3 (stage select,
//        stage1 highest priority), i_data1..3 (generator symbols), i_key (one-hot buttons);
//        o_busy (capture/input phase), o_step (next expected index), o_pass, o_fail (verdicts).
module seq_checker
    import game_pkg::*;
#(
    parameter  int SEQ_LEN = 4,
    parameter  int TIMEOUT = 1000,
    localparam int IW      = $clog2(SEQ_LEN)
)
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_stage1,
    input  logic          i_stage2,
    input  logic          i_stage3,
    input  logic [1:0]    i_data1,
    input  logic [1:0]    i_data2,
    input  logic [1:0]    i_data3,
    input  logic [3:0]    i_key,
    output logic          o_busy,
    output logic [IW-1:0] o_step,
    output logic          o_pass,
    output logic          o_fail
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    chk_state_t    r_state, w_state_nxt;
    logic [IW-1:0] r_cnt, w_cnt_nxt;
    logic [IW-1:0] r_step, w_step_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    sym_t          r_buf [SEQ_LEN];

    logic          w_press, w_valid;
    sym_t          w_sym, w_dsel;
    logic          w_start, w_buf_we;
    logic [IW-1:0] w_buf_idx;

    press_detect u_press (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key   (i_key),
        .o_press (w_press),
        .o_valid (w_valid),
        .o_sym   (w_sym)
    );

    assign w_dsel  = i_stage1 ? i_data1 : i_stage2 ? i_data2 : i_data3;
    assign w_start = i_start & (i_stage1 | i_stage2 | i_stage3);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = r_step;
        w_timer_nxt = r_timer;
        w_buf_we    = 1'b0;
        w_buf_idx   = r_cnt;
        // A valid start restarts capture from any state, aborting a round in progress.
        if (w_start) begin
            w_state_nxt = S_CAPTURE;
            w_cnt_nxt   = IW'(1);
            w_step_nxt  = '0;
            w_buf_we    = 1'b1;
            w_buf_idx   = '0;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    w_buf_we = 1'b1;
                    if (r_cnt == IW'(SEQ_LEN - 1)) begin
                        w_state_nxt = S_WAIT_KEY;
                        w_step_nxt  = '0;
                        w_timer_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + IW'(1);
                    end
                end
                S_WAIT_KEY: begin
                    // A press beats a simultaneous timer expiry.
                    if (w_press) begin
                        if (!w_valid || w_sym != r_buf[r_step]) w_state_nxt = S_FAIL;
                        else if (r_step == IW'(SEQ_LEN - 1))   w_state_nxt = S_PASS;
                        else begin
                            w_step_nxt  = r_step + IW'(1);
                            w_state_nxt = S_WAIT_REL;
                        end
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        w_state_nxt = S_FAIL;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                S_WAIT_REL: begin
                    if (i_key == 4'd0) begin
                        w_timer_nxt = '0;
                        w_state_nxt = S_WAIT_KEY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_step  <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_step  <= w_step_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Symbol store has no reset: every entry is rewritten during capture before any read.
    always_ff @(posedge i_clk) begin
        if (w_buf_we) r_buf[w_buf_idx] <= w_dsel;
    end

    assign o_busy = r_state inside {S_CAPTURE, S_WAIT_KEY, S_WAIT_REL};
    assign o_step = r_step;
    assign o_pass = (r_state == S_PASS);
    assign o_fail = (r_state == S_FAIL);

endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: directed self-checking bench for seq_checker (SEQ_LEN=4, TIMEOUT=10).
module tb_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stage1 = 1'b0, stage2 = 1'b0, stage3 = 1'b0;
    logic [1:0] data1 = '0, data2 = '0, data3 = '0;
    logic [3:0] key = '0;
    logic       busy, pass, fail;
    logic [1:0] step;

    int checks = 0;
    int failures = 0;

    seq_checker #(.SEQ_LEN(4), .TIMEOUT(10)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_stage1 (stage1),
        .i_stage2 (stage2),
        .i_stage3 (stage3),
        .i_data1  (data1),
        .i_data2  (data2),
        .i_data3  (data3),
        .i_key    (key),
        .o_busy   (busy),
        .o_step   (step),
        .o_pass   (pass),
        .o_fail   (fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Patterns are packed with symbol 0 in bits [1:0].
    task automatic capture(input logic [2:0] stg, input logic [7:0] p1, input logic [7:0] p2,
                           input logic [7:0] p3);
        {stage1, stage2, stage3} = stg;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data1 = p1[2*i +: 2];
            data2 = p2[2*i +: 2];
            data3 = p3[2*i +: 2];
            tick();
            start = 1'b0;
            if (i == 0) begin
                check("busy_rise", busy, 1'b1);
                check("start_clr", {pass, fail}, 2'b00);
            end
        end
    endtask

    task automatic hit(input logic [3:0] k);
        key = k;
        tick();
    endtask

    task automatic rel();
        key = 4'd0;
        tick();
    endtask

    initial begin
        ticks(2);
        check("rst_busy", busy, 1'b0);
        check("rst_step", step, 2'd0);
        check("rst_pf", {pass, fail}, 2'b00);
        rst_n = 1'b1;
        tick();

        // Capture 1,3,0,2 from stage 2 and play it back correctly.
        capture(3'b010, 8'hE4, 8'h8D, 8'hE4);
        check("cap_step", step, 2'd0);
        check("cap_busy", busy, 1'b1);
        hit(4'b0010); check("walk1", step, 2'd1); rel();
        hit(4'b1000); check("walk2", step, 2'd2); rel();
        hit(4'b0001); check("walk3", step, 2'd3); rel();
        hit(4'b0100);
        check("pass_pf", {pass, fail}, 2'b10);
        check("pass_busy", busy, 1'b0);
        rel();
        check("pass_hold", pass, 1'b1);

        // Wrong second key.
        capture(3'b010, 8'hE4, 8'h8D, 8'hE4);
        hit(4'b0010); rel();
        hit(4'b0100);
        check("wrong_pf", {pass, fail}, 2'b01);
        check("wrong_busy", busy, 1'b0);
        rel();

        // Timeout: fail exactly 10 cycles after entering WAIT_KEY.
        capture(3'b010, 8'hE4, 8'h8D, 8'hE4);
        ticks(9);
        check("to_early", fail, 1'b0);
        tick();
        check("to_fire", fail, 1'b1);
        check("to_busy", busy, 1'b0);

        // Press on the expiry cycle wins; release restarts the timer.
        capture(3'b010, 8'hE4, 8'h8D, 8'hE4);
        ticks(9);
        hit(4'b0010);
        check("to_press_fail", fail, 1'b0);
        check("to_press_step", step, 2'd1);
        rel();
        ticks(9);
        check("to_rearm", fail, 1'b0);
        tick();
        check("to_refire", fail, 1'b1);

        // Held key advances one step only; multi-bit press fails.
        capture(3'b010, 8'hE4, 8'h8D, 8'hE4);
        hit(4'b0010);
        ticks(3);
        check("held_step", step, 2'd1);
        check("held_busy", {busy, fail}, 2'b10);
        rel();
        hit(4'b1100);
        check("multi_hi", fail, 1'b1);
        rel();
        capture(3'b010, 8'hE4, 8'h8D, 8'hE4);
        hit(4'b0011);
        check("multi_lo", fail, 1'b1);
        rel();

        // Restart mid-WAIT_KEY with a new pattern 2,2,1,0.
        capture(3'b010, 8'hE4, 8'h8D, 8'hE4);
        hit(4'b0010); rel();
        check("pre_restart", step, 2'd1);
        capture(3'b010, 8'hE4, 8'h1A, 8'hE4);
        check("restart_step", step, 2'd0);
        hit(4'b0100); rel();
        hit(4'b0100); rel();
        hit(4'b0010); rel();
        hit(4'b0001);
        check("restart_pass", {pass, fail}, 2'b10);
        rel();

        // Asynchronous reset during capture.
        stage2 = 1'b1; data2 = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("cap_mid", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_step", step, 2'd0);
        check("arst_pf", {pass, fail}, 2'b00);
        #2;
        rst_n = 1'b1;
        tick();
        check("arst_idle", busy, 1'b0);

        // stage1 beats stage3: data1 = 3,0,1,2 while data3 = 0,1,2,3.
        capture(3'b101, 8'h93, 8'h8D, 8'hE4);
        hit(4'b1000); rel();
        hit(4'b0001); rel();
        hit(4'b0010); rel();
        hit(4'b0100);
        check("prio_pass", {pass, fail}, 2'b10);
        rel();

        // No stage selected: start is ignored and the verdict is kept.
        {stage1, stage2, stage3} = 3'b000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("nostage_busy", busy, 1'b0);
        tick();
        check("nostage_keep", {busy, pass}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
# seq_checker

Player-side checker for the pattern game. On `start` it captures `SEQ_LEN` consecutive 2-bit symbols from the active stage's pattern-generator output, one per clock. It then accepts one key press per step and compares each press against the captured symbol. It reports `pass` or `fail` to the game controller, and sits between the pattern generator's `data1/data2/data3` outputs and the score/LED logic.

## Interface
- `SEQ_LEN`, default 4: symbols per round; legal range 2..16. `IW = $clog2(SEQ_LEN)`.
- `TIMEOUT`, default 1000: maximum cycles allowed between presses; legal range 1..2^20.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins capture.
- `stage1`, `stage2`, `stage3`  in  1 each  stage select; priority stage1 > stage2 > stage3.
- `data1`, `data2`, `data3`  in  2 each  pattern symbols from the generator, one per stage.
- `key`  in  4  player buttons; one-hot level; synchronous to `clk` and debounced upstream.
- `busy`  out  1  high during capture and input phases.
- `step`  out  IW  index of the next expected symbol.
- `pass`  out  1  level; high after the whole sequence is matched.
- `fail`  out  1  level; high after a wrong key or a timeout.

## Operation
- FSM states: IDLE, CAPTURE, WAIT_KEY, WAIT_REL, PASS, FAIL.
- Selected symbol `dsel` = `data1` if `stage1`, else `data2` if `stage2`, else `data3` if `stage3`. With no stage set, `start` is ignored.
- IDLE / PASS / FAIL, `start` with a valid stage:
  - write `dsel` to `buf[0]`;
  - set `cnt` = 1;
  - go to CAPTURE;
  - clear `pass` and `fail`.
- CAPTURE:
  - write `dsel` to `buf[cnt]`;
  - when `cnt == SEQ_LEN-1`, go to WAIT_KEY with `step` = 0 and the timer cleared.
- WAIT_KEY:
  - a press is a rising edge of "key non-zero" (registered previous value);
  - press with exactly one bit set: encode `key[0..3]` to symbol 0..3 and compare with `buf[step]`;
  - press with more than one bit set is always a mismatch;
  - mismatch: go to FAIL;
  - match on the last step: go to PASS;
  - any other match: increment `step` and go to WAIT_REL.
- WAIT_REL: wait until `key == 0`, clear the timer, return to WAIT_KEY. The timer does not run in this state.
- Timer: counts in WAIT_KEY only. On reaching `TIMEOUT-1` with no press, go to FAIL.
- PASS / FAIL: hold `pass` / `fail` high until the next valid `start` or reset.
- `start` in CAPTURE, WAIT_KEY or WAIT_REL aborts the round and restarts capture exactly as from IDLE. A stage change mid-round has no effect on already-captured symbols.
- `buf` is not reset. It is always fully rewritten before it is read.

## Timing
- Reset values: state IDLE, `busy` 0, `step` 0, `pass` 0, `fail` 0, timer 0, previous-key register 0.
- Capture latency: the `start` edge captures symbol 0; the next `SEQ_LEN-1` edges capture symbols 1..SEQ_LEN-1. `busy` rises one cycle after `start`.
- The verdict registers on the edge that samples the deciding press. `pass` / `fail` are visible the following cycle; `busy` falls in that same cycle.
- A press and timer expiry in the same cycle: the press wins.
- A key held from a previous step generates no new press until it is released.
- `rst` assertion mid-round returns to IDLE immediately, asynchronously. Release is synchronous to `clk`.

## Structure
- Shared package `game_pkg`:
  - FSM state enum `chk_state_t`;
  - symbol type `sym_t` (`logic [1:0]`);
  - key-to-symbol encode function.
- One natural sub-module: `press_detect` (edge detection plus one-hot validity check), which outputs `press` and `press_sym`. All other logic is inline.

## Test plan
- Capture and pass: stage2 selected, `data2` = 1,3,0,2 on consecutive cycles after `start`; press key[1], key[3], key[0], key[2], releasing between presses. Expect `pass` = 1, `fail` = 0, `step` walks 0→1→2→3.
- Wrong key: same sequence; the second press is key[2]. Expect `fail` = 1 on the cycle after that press and `busy` = 0.
- Timeout: `TIMEOUT` = 10, no press. Expect `fail` = 1 exactly 10 cycles after entering WAIT_KEY. A press arriving on cycle 10 instead yields a compare result, not a timeout.
- Held and multi-bit keys: key[1] held across two steps advances only one step. `key` = 4'b0011 on a press gives `fail`.
- Restart and reset: `start` mid-WAIT_KEY recaptures with `step` = 0 and `pass`/`fail` cleared. `rst` low mid-CAPTURE returns all outputs to 0 immediately.
- Stage priority: `stage1` and `stage3` both high, so `data1` is captured. No stage high: `start` leaves the FSM in IDLE.
